// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Lanes covered by an access of the given size, before offset shifting.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        case (size_e'(sz))
            SZ_B:    lane_mask = 4'b0001;
            SZ_H:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (size_e'(sz))
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Core request/response and SRAM port bundle of the alignment unit.
interface lsu_align_if #(
    parameter int AW = 12
) ();
    logic          req_i;
    logic          we_i;
    logic [1:0]    size_i;
    logic          unsigned_i;
    logic [31:0]   addr_i;
    logic [31:0]   wdata_i;
    logic          busy_o;
    logic          valid_o;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic          mem_we_o;
    logic          mem_re_o;
    logic [3:0]    mem_ble_o;
    logic [AW-1:0] mem_add_o;
    logic [31:0]   mem_d_o;
    logic [31:0]   mem_d_i;

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_d_i,
        output busy_o, valid_o, rdata_o, err_o,
               mem_we_o, mem_re_o, mem_ble_o, mem_add_o, mem_d_o
    );

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_d_i,
        input  busy_o, valid_o, rdata_o, err_o,
               mem_we_o, mem_re_o, mem_ble_o, mem_add_o, mem_d_o
    );
endinterface

// File: rtl/lsu_load_extract.sv
// Shifts raw load bytes down by the byte offset and sign/zero-extends them.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [55:0] i_data,     // {second word bytes 2..0, first word}
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [31:0] w_shift;

    assign w_shift = 32'(i_data >> {i_off, 3'b000});

    always_comb begin
        o_data = w_shift;
        case (size_e'(i_size))
            SZ_B:    o_data = {{24{~i_unsigned & w_shift[7]}},  w_shift[7:0]};
            SZ_H:    o_data = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end
endmodule

// File: rtl/lsu_align.sv
// RV32 load/store alignment in front of a word SRAM; splits word-crossing accesses.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int SIZE        = 4096,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    lsu_align_if.slave bus
);
    localparam int AW = $clog2(SIZE);

    state_e        r_state, w_state_next;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_off, r_size;
    logic          r_unsigned, r_we;
    logic [31:0]   r_wdata, r_first, r_rdata;
    logic          r_valid, r_err;

    logic [1:0]    w_off;
    logic [AW-1:0] w_word;
    logic          w_split, w_err, w_in_split;
    logic [1:0]    w_cur_off, w_cur_size;
    logic          w_cur_uns;
    logic [31:0]   w_cur_wd;
    logic [7:0]    w_lanes;
    logic [63:0]   w_wd_sh;
    logic [55:0]   w_ld_raw;
    logic [31:0]   w_ld_data;

    assign w_off   = bus.addr_i[1:0];
    assign w_word  = bus.addr_i[AW+1:2];
    assign w_split = ({1'b0, w_off} + size_bytes(bus.size_i)) > 3'd4;
    assign w_err   = (bus.size_i == 2'd3) || (|bus.addr_i[31:AW+2])
                   || (w_split && !MISALIGN_EN);

    // Both halves of a split come from one shift: low nibble/word is the
    // first access, the spill into the high part is the second.
    assign w_in_split = (r_state == SPLIT);
    assign w_cur_off  = w_in_split ? r_off      : w_off;
    assign w_cur_size = w_in_split ? r_size     : bus.size_i;
    assign w_cur_uns  = w_in_split ? r_unsigned : bus.unsigned_i;
    assign w_cur_wd   = w_in_split ? r_wdata    : bus.wdata_i;
    assign w_lanes    = {4'b0000, lane_mask(w_cur_size)} << w_cur_off;
    assign w_wd_sh    = {32'd0, w_cur_wd} << {w_cur_off, 3'b000};
    assign w_ld_raw   = w_in_split ? {bus.mem_d_i[23:0], r_first}
                                   : {24'd0, bus.mem_d_i};

    lsu_load_extract u_extract (
        .i_data     (w_ld_raw),
        .i_off      (w_cur_off),
        .i_size     (w_cur_size),
        .i_unsigned (w_cur_uns),
        .o_data     (w_ld_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        bus.mem_we_o  = 1'b0;
        bus.mem_re_o  = 1'b0;
        bus.mem_ble_o = 4'b0000;
        bus.mem_add_o = '0;
        bus.mem_d_o   = 32'd0;
        case (r_state)
            IDLE: begin
                if (bus.req_i && !w_err) begin
                    bus.mem_we_o  = bus.we_i;
                    bus.mem_re_o  = !bus.we_i;
                    bus.mem_ble_o = w_lanes[3:0];
                    bus.mem_add_o = w_word;
                    bus.mem_d_o   = w_wd_sh[31:0];
                    if (w_split) w_state_next = SPLIT;
                end
            end
            SPLIT: begin
                bus.mem_we_o  = r_we;
                bus.mem_re_o  = !r_we;
                bus.mem_ble_o = w_lanes[7:4];
                bus.mem_add_o = r_addr;
                bus.mem_d_o   = w_wd_sh[63:32];
                w_state_next  = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_addr     <= '0;
            r_off      <= 2'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= 32'd0;
            r_first    <= 32'd0;
            r_rdata    <= 32'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (r_state == IDLE && bus.req_i) begin
                if (w_err) begin
                    r_valid <= 1'b1;
                    r_err   <= 1'b1;
                end else if (w_split) begin
                    r_addr     <= (w_word == AW'(SIZE - 1)) ? '0 : w_word + AW'(1);
                    r_off      <= w_off;
                    r_size     <= bus.size_i;
                    r_unsigned <= bus.unsigned_i;
                    r_we       <= bus.we_i;
                    r_wdata    <= bus.wdata_i;
                    r_first    <= bus.mem_d_i;
                end else begin
                    r_valid <= 1'b1;
                    if (!bus.we_i) r_rdata <= w_ld_data;
                end
            end else if (r_state == SPLIT) begin
                r_valid <= 1'b1;
                if (!r_we) r_rdata <= w_ld_data;
            end
        end
    end

    assign bus.busy_o  = w_in_split;
    assign bus.valid_o = r_valid;
    assign bus.err_o   = r_err;
    assign bus.rdata_o = r_rdata;
endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-lane SRAM model on the main instance.
module tb_lsu_align;
    import lsu_pkg::*;

    localparam int SIZE = 4096;
    localparam int AW   = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    lsu_align_if #(.AW(AW)) bus ();
    lsu_align_if #(.AW(AW)) bus2 ();

    lsu_align #(.SIZE(SIZE), .MISALIGN_EN(1'b1)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    lsu_align #(.SIZE(SIZE), .MISALIGN_EN(1'b0)) dut2 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus2)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [SIZE] = '{default: 32'd0};

    always @(posedge clk) begin
        if (bus.mem_we_o)
            for (int i = 0; i < 4; i++)
                if (bus.mem_ble_o[i]) mem[bus.mem_add_o][8*i +: 8] <= bus.mem_d_o[8*i +: 8];
    end

    always_comb begin
        bus.mem_d_i = 32'd0;
        for (int i = 0; i < 4; i++)
            if (bus.mem_ble_o[i]) bus.mem_d_i[8*i +: 8] = mem[bus.mem_add_o][8*i +: 8];
    end

    assign bus2.mem_d_i = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.we_i       = we;
        bus.size_i     = sz;
        bus.unsigned_i = uns;
        bus.addr_i     = a;
        bus.wdata_i    = wd;
        bus.req_i      = 1'b1;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_i = 0; bus.we_i = 0; bus.size_i = 0; bus.unsigned_i = 0;
        bus.addr_i = 0; bus.wdata_i = 0;
        bus2.req_i = 0; bus2.we_i = 0; bus2.size_i = 0; bus2.unsigned_i = 0;
        bus2.addr_i = 0; bus2.wdata_i = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, bus.busy_o},  32'd0);
        chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_err",   {31'd0, bus.err_o},   32'd0);
        chk("rst_rdata", bus.rdata_o,          32'd0);
        chk("rst_ble",   {28'd0, bus.mem_ble_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Byte store then signed/unsigned byte loads
        issue(1'b1, SZ_B, 1'b0, 32'h102, 32'hA5);
        chk("sb_ble",  {28'd0, bus.mem_ble_o}, 32'h4);
        chk("sb_d",    bus.mem_d_o, 32'h00A50000);
        chk("sb_we",   {31'd0, bus.mem_we_o}, 32'd1);
        chk("sb_add",  {20'd0, bus.mem_add_o}, 32'h40);
        tick;
        chk("sb_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("sb_err",   {31'd0, bus.err_o},   32'd0);
        issue(1'b0, SZ_B, 1'b0, 32'h102, 32'h0);
        chk("lb_re",  {31'd0, bus.mem_re_o}, 32'd1);
        chk("lb_ble", {28'd0, bus.mem_ble_o}, 32'h4);
        tick;
        chk("lb_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("lb_rdata", bus.rdata_o, 32'hFFFFFFA5);
        issue(1'b0, SZ_B, 1'b1, 32'h102, 32'h0);
        tick;
        chk("lbu_rdata", bus.rdata_o, 32'h000000A5);

        // Misaligned word store split across words 0x80/0x81
        issue(1'b1, SZ_W, 1'b0, 32'h201, 32'h11223344);
        chk("sw1_ble", {28'd0, bus.mem_ble_o}, 32'hE);
        chk("sw1_d",   bus.mem_d_o, 32'h22334400);
        chk("sw1_add", {20'd0, bus.mem_add_o}, 32'h80);
        tick;
        chk("sw2_busy",  {31'd0, bus.busy_o},  32'd1);
        chk("sw2_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("sw2_add",   {20'd0, bus.mem_add_o}, 32'h81);
        chk("sw2_ble",   {28'd0, bus.mem_ble_o}, 32'h1);
        chk("sw2_d",     bus.mem_d_o, 32'h00000011);
        chk("sw2_we",    {31'd0, bus.mem_we_o}, 32'd1);
        tick;
        chk("sw_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("sw_busy",  {31'd0, bus.busy_o},  32'd0);
        chk("sw_rdata_held", bus.rdata_o, 32'h000000A5);
        issue(1'b0, SZ_W, 1'b0, 32'h201, 32'h0);
        tick;
        chk("lw_busy",  {31'd0, bus.busy_o},  32'd1);
        chk("lw_novalid", {31'd0, bus.valid_o}, 32'd0);
        tick;
        chk("lw_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("lw_rdata", bus.rdata_o, 32'h11223344);

        // Split halfword load at 0x003
        issue(1'b1, SZ_B, 1'b0, 32'h3, 32'hEF);
        tick;
        issue(1'b1, SZ_B, 1'b0, 32'h4, 32'hBE);
        tick;
        issue(1'b0, SZ_H, 1'b1, 32'h3, 32'h0);
        chk("lhu1_ble", {28'd0, bus.mem_ble_o}, 32'h8);
        tick;
        chk("lhu2_ble", {28'd0, bus.mem_ble_o}, 32'h1);
        chk("lhu2_add", {20'd0, bus.mem_add_o}, 32'h1);
        tick;
        chk("lhu_rdata", bus.rdata_o, 32'h0000BEEF);
        issue(1'b0, SZ_H, 1'b0, 32'h3, 32'h0);
        tick;
        tick;
        chk("lh_rdata", bus.rdata_o, 32'hFFFFBEEF);

        // Word store at top of memory wraps the second access to word 0
        issue(1'b1, SZ_W, 1'b0, 32'h3FFE, 32'hCAFEBABE);
        chk("wrap1_add", {20'd0, bus.mem_add_o}, 32'hFFF);
        chk("wrap1_ble", {28'd0, bus.mem_ble_o}, 32'hC);
        chk("wrap1_d",   bus.mem_d_o, 32'hBABE0000);
        tick;
        chk("wrap2_add", {20'd0, bus.mem_add_o}, 32'h0);
        chk("wrap2_ble", {28'd0, bus.mem_ble_o}, 32'h3);
        chk("wrap2_d",   bus.mem_d_o, 32'h0000CAFE);
        tick;
        chk("wrap_valid", {31'd0, bus.valid_o}, 32'd1);
        issue(1'b0, SZ_W, 1'b0, 32'h3FFE, 32'h0);
        tick;
        tick;
        chk("wrap_rdata", bus.rdata_o, 32'hCAFEBABE);

        // Illegal size and out-of-range address
        issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        chk("sz3_re",  {31'd0, bus.mem_re_o}, 32'd0);
        chk("sz3_ble", {28'd0, bus.mem_ble_o}, 32'd0);
        tick;
        chk("sz3_err",   {31'd0, bus.err_o},   32'd1);
        chk("sz3_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("sz3_rdata", bus.rdata_o, 32'hCAFEBABE);
        issue(1'b1, SZ_W, 1'b0, 32'h4000, 32'h12345678);
        chk("oor_we", {31'd0, bus.mem_we_o}, 32'd0);
        tick;
        chk("oor_err",   {31'd0, bus.err_o},   32'd1);
        chk("oor_valid", {31'd0, bus.valid_o}, 32'd1);
        @(negedge clk);
        bus.req_i = 1'b0;
        tick;
        chk("idle_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("idle_err",   {31'd0, bus.err_o},   32'd0);

        // Misalignment flagged when splitting is disabled
        @(negedge clk);
        bus2.we_i = 1'b0; bus2.size_i = SZ_W; bus2.unsigned_i = 1'b0;
        bus2.addr_i = 32'h5; bus2.req_i = 1'b1;
        #1;
        chk("mis_re", {31'd0, bus2.mem_re_o}, 32'd0);
        tick;
        chk("mis_err",   {31'd0, bus2.err_o},   32'd1);
        chk("mis_valid", {31'd0, bus2.valid_o}, 32'd1);
        chk("mis_busy",  {31'd0, bus2.busy_o},  32'd0);
        @(negedge clk);
        bus2.addr_i = 32'h4;
        #1;
        chk("al_re", {31'd0, bus2.mem_re_o}, 32'd1);
        tick;
        chk("al_err", {31'd0, bus2.err_o}, 32'd0);
        @(negedge clk);
        bus2.req_i = 1'b0;

        // Reset during the second half of a split store
        issue(1'b1, SZ_W, 1'b0, 32'h301, 32'hDEADBEEF);
        chk("rsp1_ble", {28'd0, bus.mem_ble_o}, 32'hE);
        tick;
        chk("rsp_busy", {31'd0, bus.busy_o}, 32'd1);
        #2;
        rstn = 1'b0;
        bus.req_i = 1'b0;
        #1;
        chk("rsp_busy_clr", {31'd0, bus.busy_o},   32'd0);
        chk("rsp_we_clr",   {31'd0, bus.mem_we_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick;
        chk("rsp_novalid", {31'd0, bus.valid_o}, 32'd0);
        chk("rsp_rdata",   bus.rdata_o, 32'd0);
        chk("rsp_mem_lo",  mem[12'hC0], 32'hADBEEF00);
        chk("rsp_mem_hi",  mem[12'hC1], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
